// File: rtl/pc_conf_readback_pkg.sv
// Shared types for the configuration readback path: FSM states, the
// {index, value} output word and the {first, last} dump request.
package pc_conf_readback_pkg;

    localparam int PKG_NCONF = 16;
    localparam int PKG_NREG  = 64;
    localparam int PKG_NIDX  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DUMP = 2'd1,
        CHG  = 2'd2
    } state_t;

    typedef struct packed {
        logic [PKG_NIDX-1:0]  idx;
        logic [PKG_NCONF-1:0] value;
    } out_word_t;

    typedef struct packed {
        logic [PKG_NIDX-1:0] first;
        logic [PKG_NIDX-1:0] last;
    } req_t;

    // Clip the requested last index to the highest register that exists.
    function automatic logic [PKG_NIDX-1:0] clamp_last(
        input logic [PKG_NIDX-1:0] last,
        input logic [PKG_NIDX-1:0] max_idx
    );
        return (last > max_idx) ? max_idx : last;
    endfunction

endpackage

// File: rtl/pc_conf_readback_conf_reg_shadow.sv
// Shadow copy of the last value reported for every configuration register.
// One combinational read port, one synchronous write port, async clear.
module conf_reg_shadow #(
    parameter int Nconf = 16,
    parameter int Nreg  = 64,
    parameter int AW    = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [AW-1:0]    rd_idx,
    output logic [Nconf-1:0] rd_data,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_idx,
    input  logic [Nconf-1:0] wr_data
);

    logic [Nconf-1:0] mem [Nreg];

    assign rd_data = mem[rd_idx];

    // Storage: cleared to zero on reset so every nonzero register is reported once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < Nreg; k++) begin
                mem[k] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

endmodule

// File: rtl/pc_conf_readback.sv
// Reads the live configuration register array back toward the PC: range
// dumps on request, plus a background scan that reports changed registers.
module pc_conf_readback
    import pc_conf_readback_pkg::*;
#(
    parameter int Nconf = PKG_NCONF,
    parameter int Nreg  = PKG_NREG,
    parameter int Nidx  = PKG_NIDX
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [Nreg*Nconf-1:0] conf_reg_out,
    input  logic                  report_en,
    input  logic                  req_v,
    input  logic [2*Nidx-1:0]     req_d,
    output logic                  req_a,
    output logic                  out_v,
    output logic [Nidx+Nconf-1:0] out_d,
    input  logic                  out_a,
    output logic                  busy
);

    localparam int              AW       = $clog2(Nreg);
    localparam logic [Nidx-1:0] LAST_IDX = Nidx'(Nreg - 1);

    state_t          state, state_nx;
    logic            rst_done;
    logic [Nidx-1:0] ptr, ptr_nx;
    logic [Nidx-1:0] lastc, lastc_nx;
    logic            out_v_r, out_v_nx;
    out_word_t       out_word, out_word_nx;

    logic [Nconf-1:0] conf_arr [Nreg];
    logic [Nconf-1:0] sh_rd;
    logic             sh_we;
    req_t             req_w;
    logic [Nidx-1:0]  req_lastc;
    logic [Nidx-1:0]  nxt_idx;
    logic             accept;

    // Unflatten the live register bus so registers can be picked by index.
    always_comb begin
        for (int k = 0; k < Nreg; k++) begin
            conf_arr[k] = conf_reg_out[k*Nconf +: Nconf];
        end
    end

    conf_reg_shadow #(
        .Nconf (Nconf),
        .Nreg  (Nreg),
        .AW    (AW)
    ) u_shadow (
        .clk     (clk),
        .reset   (reset),
        .rd_idx  (ptr[AW-1:0]),
        .rd_data (sh_rd),
        .wr_en   (sh_we),
        .wr_idx  (out_word.idx[AW-1:0]),
        .wr_data (out_word.value)
    );

    assign req_w     = req_t'(req_d);
    assign req_lastc = clamp_last(req_w.first == req_w.first ? req_w.last : req_w.last, LAST_IDX);
    assign nxt_idx   = out_word.idx + Nidx'(1);
    assign accept    = out_v_r && out_a;

    // Next-state and datapath decisions; a request in IDLE pre-empts the scan.
    always_comb begin
        state_nx    = state;
        ptr_nx      = ptr;
        lastc_nx    = lastc;
        out_v_nx    = out_v_r;
        out_word_nx = out_word;
        sh_we       = 1'b0;
        case (state)
            IDLE: begin
                if (req_v && rst_done) begin
                    if (req_w.first <= req_lastc) begin
                        lastc_nx          = req_lastc;
                        out_word_nx.idx   = req_w.first;
                        out_word_nx.value = conf_arr[req_w.first[AW-1:0]];
                        out_v_nx          = 1'b1;
                        state_nx          = DUMP;
                    end
                end else if (report_en && rst_done) begin
                    if (conf_arr[ptr[AW-1:0]] != sh_rd) begin
                        out_word_nx.idx   = ptr;
                        out_word_nx.value = conf_arr[ptr[AW-1:0]];
                        out_v_nx          = 1'b1;
                        state_nx          = CHG;
                    end else begin
                        ptr_nx = (ptr == LAST_IDX) ? '0 : ptr + Nidx'(1);
                    end
                end
            end
            DUMP: begin
                if (accept) begin
                    sh_we = 1'b1;
                    if (out_word.idx == lastc) begin
                        out_v_nx = 1'b0;
                        state_nx = IDLE;
                    end else begin
                        out_word_nx.idx   = nxt_idx;
                        out_word_nx.value = conf_arr[nxt_idx[AW-1:0]];
                    end
                end
            end
            CHG: begin
                if (accept) begin
                    sh_we    = 1'b1;
                    ptr_nx   = (ptr == LAST_IDX) ? '0 : ptr + Nidx'(1);
                    out_v_nx = 1'b0;
                    state_nx = IDLE;
                end
            end
            default: begin
                out_v_nx = 1'b0;
                state_nx = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Reset-release marker plus scan pointer, dump limit and output word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_done <= 1'b0;
            ptr      <= '0;
            lastc    <= '0;
            out_v_r  <= 1'b0;
            out_word <= '0;
        end else begin
            rst_done <= 1'b1;
            ptr      <= ptr_nx;
            lastc    <= lastc_nx;
            out_v_r  <= out_v_nx;
            out_word <= out_word_nx;
        end
    end

    assign out_v = out_v_r;
    assign out_d = out_word;
    assign req_a = (state == IDLE) && rst_done;
    assign busy  = (state != IDLE);

endmodule

// File: tb/tb_pc_conf_readback.sv
module tb_pc_conf_readback;

    localparam int NCONF = 16;
    localparam int NREG  = 64;
    localparam int NIDX  = 8;

    logic                   clk;
    logic                   reset;
    logic [NREG*NCONF-1:0]  conf_flat;
    logic                   report_en;
    logic                   req_v;
    logic [2*NIDX-1:0]      req_d;
    logic                   req_a;
    logic                   out_v;
    logic [NIDX+NCONF-1:0]  out_d;
    logic                   out_a;
    logic                   busy;

    logic [NCONF-1:0] regs [NREG];

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 0;

    // reference model state
    bit         m_valid;
    bit         m_chg;
    bit         m_rst_done;
    int         m_ptr;
    int         m_idx;
    logic [15:0] m_val;
    logic [15:0] m_shadow [NREG];
    int         dump_q [$];

    pc_conf_readback dut (
        .clk          (clk),
        .reset        (reset),
        .conf_reg_out (conf_flat),
        .report_en    (report_en),
        .req_v        (req_v),
        .req_d        (req_d),
        .req_a        (req_a),
        .out_v        (out_v),
        .out_d        (out_d),
        .out_a        (out_a),
        .busy         (busy)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always_comb begin
        for (int k = 0; k < NREG; k++) conf_flat[k*NCONF +: NCONF] = regs[k];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: a queue of pending dump indices, a shadow of
    // reported values and a scan position; outputs follow from those.
    initial forever begin
        @(posedge clk or negedge reset);
        if (!reset) begin
            m_valid = 0; m_chg = 0; m_rst_done = 0; m_ptr = 0; m_idx = 0; m_val = 0;
            dump_q.delete();
            for (int k = 0; k < NREG; k++) m_shadow[k] = 0;
        end else begin
            if (m_valid) begin
                if (out_a) begin
                    m_shadow[m_idx] = m_val;
                    if (dump_q.size() > 0) begin
                        m_idx = dump_q.pop_front();
                        m_val = regs[m_idx];
                    end else begin
                        m_valid = 0;
                        if (m_chg) m_ptr = (m_ptr + 1) % NREG;
                    end
                end
            end else if (m_rst_done) begin
                if (req_v) begin
                    int f, l;
                    f = int'(req_d[15:8]);
                    l = int'(req_d[7:0]);
                    if (l > NREG - 1) l = NREG - 1;
                    for (int i = f; i <= l; i++) dump_q.push_back(i);
                    if (dump_q.size() > 0) begin
                        m_idx = dump_q.pop_front();
                        m_val = regs[m_idx];
                        m_valid = 1; m_chg = 0;
                    end
                end else if (report_en) begin
                    if (regs[m_ptr] != m_shadow[m_ptr]) begin
                        m_idx = m_ptr; m_val = regs[m_ptr];
                        m_valid = 1; m_chg = 1;
                    end else begin
                        m_ptr = (m_ptr + 1) % NREG;
                    end
                end
            end
            m_rst_done = 1;
        end
    end

    // Per-cycle comparison of the DUT against the model.
    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            chk("out_v", 32'(out_v), 32'(m_valid));
            if (m_valid) chk("out_d", 32'(out_d), {8'h0, 8'(m_idx), m_val});
            chk("req_a", 32'(req_a), 32'(m_rst_done && !m_valid));
            chk("busy", 32'(busy), 32'(m_valid));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_word(input int idx, input int budget, output bit found, output logic [15:0] val);
        found = 0; val = '0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (out_v && int'(out_d[23:16]) == idx) begin
                found = 1; val = out_d[15:0];
                break;
            end
        end
    endtask

    initial begin
        bit found;
        logic [15:0] v;
        int cnt, first_cyc, nz;
        logic [15:0] v10;

        for (int k = 0; k < NREG; k++) regs[k] = '0;
        report_en = 0; req_v = 0; req_d = '0; out_a = 1;
        reset = 1;
        #2 reset = 0;
        cmp_en = 1;

        // reset behaviour
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("reset_out_v", 32'(out_v), 0);
        chk("reset_req_a", 32'(req_a), 0);
        @(posedge clk); #1 reset = 1;
        #1 chk("release_req_a", 32'(req_a), 0);
        tick();
        @(negedge clk);
        chk("ready_req_a", 32'(req_a), 1);

        // plain dump 3..5
        tick();
        regs[3] = 16'h1111; regs[4] = 16'h2222; regs[5] = 16'h3333;
        req_v = 1; req_d = {8'd3, 8'd5};
        tick();
        req_v = 0;
        @(negedge clk); chk("dump_w0", 32'(out_d), 32'h03_1111);
        @(negedge clk); chk("dump_w1", 32'(out_d), 32'h04_2222);
        @(negedge clk); chk("dump_w2", 32'(out_d), 32'h05_3333);
        @(negedge clk);
        chk("dump_end_v", 32'(out_v), 0);
        chk("dump_end_req_a", 32'(req_a), 1);

        // backpressure with snapshot
        tick();
        req_v = 1; req_d = {8'd3, 8'd5};
        tick();
        req_v = 0;
        tick();
        out_a = 0; regs[4] = 16'hBEEF;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); chk("bp_hold", 32'(out_d), 32'h04_2222);
        end
        tick();
        out_a = 1;
        @(negedge clk); chk("bp_release", 32'(out_d), 32'h04_2222);
        tick();
        report_en = 1;
        wait_word(4, 2*NREG, found, v);
        chk("beef_found", 32'(found), 1);
        chk("beef_val", 32'(v), 32'hBEEF);

        // single change report
        repeat (3*NREG) tick();
        regs[10] = 16'h00A5;
        cnt = 0; first_cyc = -1; v10 = '0;
        for (int i = 0; i < 3*NREG; i++) begin
            @(negedge clk);
            if (out_v && out_d[23:16] == 8'd10) begin
                if (cnt == 0) begin first_cyc = i + 1; v10 = out_d[15:0]; end
                cnt++;
            end
        end
        chk("chg_count", 32'(cnt), 1);
        chk("chg_val", 32'(v10), 32'h00A5);
        chk("chg_latency_ok", 32'(first_cyc >= 1 && first_cyc <= NREG + 2), 1);

        // empty range
        tick();
        report_en = 0;
        tick();
        req_v = 1; req_d = {8'd7, 8'd2};
        @(negedge clk); chk("empty_req_a", 32'(req_a), 1);
        tick();
        req_v = 0;
        cnt = 0;
        repeat (3) begin @(negedge clk); if (out_v) cnt++; end
        chk("empty_no_words", 32'(cnt), 0);

        // clipped range 60..200
        tick();
        for (int k = 60; k < 64; k++) regs[k] = 16'(16'h6000 + k);
        req_v = 1; req_d = {8'd60, 8'd200};
        tick();
        req_v = 0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_v) begin
                chk("clip_word", 32'(out_d), {8'h0, 8'(60 + cnt), 16'(16'h6000 + 60 + cnt)});
                cnt++;
            end
        end
        chk("clip_count", 32'(cnt), 4);

        // request and scan hit in the same cycle
        tick();
        for (int k = 0; k < NREG; k++) regs[k] = regs[k] ^ 16'h5A5A;
        req_v = 1; req_d = {8'd0, 8'd1}; report_en = 1;
        tick();
        req_v = 0;
        @(negedge clk); chk("prio_w0", 32'(out_d), {8'h0, 8'd0, regs[0]});
        @(negedge clk); chk("prio_w1", 32'(out_d), {8'h0, 8'd1, regs[1]});
        found = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (out_v) begin found = 1; break; end
        end
        chk("prio_scan_follows", 32'(found), 1);
        chk("prio_scan_idx", 32'(out_d[23:16] >= 8'd2), 1);
        repeat (3*NREG) tick();

        // async reset mid-dump
        report_en = 0;
        req_v = 1; req_d = {8'd0, 8'd63};
        tick();
        req_v = 0;
        repeat (4) tick();
        #2 reset = 0;
        #1 chk("async_out_v", 32'(out_v), 0);
        chk("async_busy", 32'(busy), 0);
        repeat (3) tick();
        reset = 1;
        cnt = 0;
        repeat (10) begin @(negedge clk); if (out_v) cnt++; end
        chk("post_reset_quiet", 32'(cnt), 0);

        // every nonzero register reported once after reset
        nz = 0;
        for (int k = 0; k < NREG; k++) if (regs[k] != 0) nz++;
        tick();
        report_en = 1;
        cnt = 0;
        repeat (3*NREG + 10) begin @(negedge clk); if (out_v) cnt++; end
        chk("post_reset_reports", 32'(cnt), 32'(nz));

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            tick();
            out_a = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 63) == 0) report_en = ~report_en;
            req_v = ($urandom_range(0, 15) == 0);
            req_d = {8'($urandom_range(0, 70)), 8'($urandom_range(0, 255))};
            if ($urandom_range(0, 7) == 0) regs[$urandom_range(0, NREG-1)] = 16'($urandom);
        end
        tick();
        req_v = 0; out_a = 1;
        repeat (3*NREG) tick();

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
